tlb_refill_walker: RTL

Hardware page-table walker that sits directly downstream of the TLB: it accepts a TLB miss, performs an Sv32-style two-level walk through memory, and drives the TLB's refill write port (`we`/`w_vaddr`/`w_paddr`) with the resolved 4 KiB translation. Walk failures raise a one-cycle fault pulse and produce no refill. One walk is in flight at a time.

---
 rtl/tlb_refill_walker_pkg.sv | 33 +++
 rtl/tlb_refill_walker_pte_decode.sv | 22 ++
 rtl/tlb_refill_walker.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/tlb_refill_walker_pkg.sv
// Shared constants for the TLB refill walker: address geometry, PTE field
// positions and the walker state encoding.
package tlb_refill_walker_pkg;

  localparam int VPN_WIDTH        = 20;
  localparam int PPN_WIDTH        = 20;
  localparam int PAGE_OFFSET_BITS = 12;

  localparam int VPN1_HI = 31;
  localparam int VPN1_LO = 22;
  localparam int VPN0_HI = 21;
  localparam int VPN0_LO = 12;

  localparam int PTE_V       = 0;
  localparam int PTE_R       = 1;
  localparam int PTE_W       = 2;
  localparam int PTE_X       = 3;
  localparam int PTE_PPN_HI  = 29;
  localparam int PTE_PPN_LO  = 10;
  // Top of PPN[0]; must be zero in a usable level-1 superpage leaf.
  localparam int PTE_PPN0_HI = 19;

  typedef logic [2:0] walk_state_t;

  localparam walk_state_t ST_IDLE    = 3'd0;
  localparam walk_state_t ST_L1_REQ  = 3'd1;
  localparam walk_state_t ST_L1_WAIT = 3'd2;
  localparam walk_state_t ST_L0_REQ  = 3'd3;
  localparam walk_state_t ST_L0_WAIT = 3'd4;
  localparam walk_state_t ST_REFILL  = 3'd5;
  localparam walk_state_t ST_FAULT   = 3'd6;

endpackage

// File: rtl/tlb_refill_walker_pte_decode.sv
// Combinational Sv32 PTE classifier used at both walk levels.
module tlb_refill_walker_pte_decode
  import tlb_refill_walker_pkg::*;
(
  input  logic [31:0]          pte,
  input  logic                 level1,
  output logic                 invalid,
  output logic                 leaf,
  output logic                 misaligned,
  output logic [PPN_WIDTH-1:0] ppn
);

  logic unused_pte_bits;

  assign invalid    = !pte[PTE_V] || (pte[PTE_W] && !pte[PTE_R]);
  assign leaf       = pte[PTE_R] || pte[PTE_X];
  assign misaligned = level1 && (pte[PTE_PPN0_HI:PTE_PPN_LO] != '0);
  assign ppn        = pte[PTE_PPN_HI:PTE_PPN_LO];

  assign unused_pte_bits = ^{pte[31:30], pte[9:4]};

endmodule

// File: rtl/tlb_refill_walker.sv
// Two-level Sv32 page-table walker feeding the TLB refill port.
// Define TLB_WALK_SUPERPAGE_EN to accept aligned level-1 (4 MiB) leaves.
//
// state    | meaning
// IDLE     | ready for a miss
// L1_REQ   | level-1 PTE read requested, waiting for grant
// L1_WAIT  | waiting for level-1 PTE data
// L0_REQ   | level-0 PTE read requested, waiting for grant
// L0_WAIT  | waiting for level-0 PTE data
// REFILL   | refill_we pulse
// FAULT    | walk_fault pulse
module tlb_refill_walker
  import tlb_refill_walker_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [PPN_WIDTH-1:0] root_ppn,
  input  logic                 miss_valid,
  input  logic [31:0]          miss_vaddr,
  output logic                 miss_ready,
  output logic                 mem_req,
  output logic [31:0]          mem_addr,
  input  logic                 mem_gnt,
  input  logic                 mem_rvalid,
  input  logic [31:0]          mem_rdata,
  output logic                 refill_we,
  output logic [31:0]          refill_vaddr,
  output logic [31:0]          refill_paddr,
  output logic                 walk_fault,
  output logic [31:0]          fault_vaddr
);

  localparam logic [15:0] TIMEOUT_TC = 16'(TIMEOUT_CYCLES);

  walk_state_t          state_q, state_d;
  logic [31:0]          vaddr_q, vaddr_d;
  logic [31:0]          mem_addr_q, mem_addr_d;
  logic [15:0]          wait_cnt_q, wait_cnt_d;
  logic                 refill_we_q, refill_we_d;
  logic [31:0]          refill_vaddr_q, refill_vaddr_d;
  logic [31:0]          refill_paddr_q, refill_paddr_d;
  logic                 walk_fault_q, walk_fault_d;
  logic [31:0]          fault_vaddr_q, fault_vaddr_d;

  logic                 dec_level1, dec_invalid, dec_leaf, dec_misaligned;
  logic [PPN_WIDTH-1:0] dec_ppn, refill_ppn;
  logic                 go_fault, go_refill, wait_expired;

  assign dec_level1 = (state_q == ST_L1_WAIT);

  tlb_refill_walker_pte_decode u_pte_decode (
    .pte        (mem_rdata),
    .level1     (dec_level1),
    .invalid    (dec_invalid),
    .leaf       (dec_leaf),
    .misaligned (dec_misaligned),
    .ppn        (dec_ppn)
  );

`ifndef TLB_WALK_SUPERPAGE_EN
  logic unused_misaligned;
  assign unused_misaligned = dec_misaligned;
`endif

  // A data beat in the same cycle as expiry still wins.
  assign wait_expired = (TIMEOUT_TC != 16'd0) && ((wait_cnt_q + 16'd1) == TIMEOUT_TC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      vaddr_q        <= '0;
      mem_addr_q     <= '0;
      wait_cnt_q     <= '0;
      refill_we_q    <= 1'b0;
      refill_vaddr_q <= '0;
      refill_paddr_q <= '0;
      walk_fault_q   <= 1'b0;
      fault_vaddr_q  <= '0;
    end else begin
      state_q        <= state_d;
      vaddr_q        <= vaddr_d;
      mem_addr_q     <= mem_addr_d;
      wait_cnt_q     <= wait_cnt_d;
      refill_we_q    <= refill_we_d;
      refill_vaddr_q <= refill_vaddr_d;
      refill_paddr_q <= refill_paddr_d;
      walk_fault_q   <= walk_fault_d;
      fault_vaddr_q  <= fault_vaddr_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    vaddr_d        = vaddr_q;
    mem_addr_d     = mem_addr_q;
    wait_cnt_d     = wait_cnt_q;
    refill_we_d    = 1'b0;
    refill_vaddr_d = refill_vaddr_q;
    refill_paddr_d = refill_paddr_q;
    walk_fault_d   = 1'b0;
    fault_vaddr_d  = fault_vaddr_q;
    go_fault       = 1'b0;
    go_refill      = 1'b0;
    refill_ppn     = dec_ppn;
    case (state_q)
      ST_IDLE: begin
        if (miss_valid) begin
          vaddr_d    = miss_vaddr;
          mem_addr_d = {root_ppn, miss_vaddr[VPN1_HI:VPN1_LO], 2'b00};
          state_d    = ST_L1_REQ;
        end
      end
      ST_L1_REQ: begin
        if (mem_gnt) begin
          wait_cnt_d = '0;
          state_d    = ST_L1_WAIT;
        end
      end
      ST_L1_WAIT: begin
        if (mem_rvalid) begin
          if (dec_invalid) begin
            go_fault = 1'b1;
          end else if (dec_leaf) begin
`ifdef TLB_WALK_SUPERPAGE_EN
            if (dec_misaligned) begin
              go_fault = 1'b1;
            end else begin
              go_refill  = 1'b1;
              refill_ppn = {dec_ppn[PPN_WIDTH-1:VPN0_HI-VPN0_LO+1], vaddr_q[VPN0_HI:VPN0_LO]};
            end
`else
            go_fault = 1'b1;
`endif
          end else begin
            mem_addr_d = {dec_ppn, vaddr_q[VPN0_HI:VPN0_LO], 2'b00};
            state_d    = ST_L0_REQ;
          end
        end else if (wait_expired) begin
          go_fault = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      ST_L0_REQ: begin
        if (mem_gnt) begin
          wait_cnt_d = '0;
          state_d    = ST_L0_WAIT;
        end
      end
      ST_L0_WAIT: begin
        if (mem_rvalid) begin
          if (dec_invalid || !dec_leaf) go_fault  = 1'b1;
          else                          go_refill = 1'b1;
        end else if (wait_expired) begin
          go_fault = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (go_fault) begin
      state_d       = ST_FAULT;
      walk_fault_d  = 1'b1;
      fault_vaddr_d = vaddr_q;
    end
    if (go_refill) begin
      state_d        = ST_REFILL;
      refill_we_d    = 1'b1;
      refill_vaddr_d = {vaddr_q[VPN1_HI -: VPN_WIDTH], {PAGE_OFFSET_BITS{1'b0}}};
      refill_paddr_d = {refill_ppn, {PAGE_OFFSET_BITS{1'b0}}};
    end
  end

  always_comb begin
    miss_ready = (state_q == ST_IDLE);
    mem_req    = (state_q == ST_L1_REQ) || (state_q == ST_L0_REQ);
  end

  assign mem_addr     = mem_addr_q;
  assign refill_we    = refill_we_q;
  assign refill_vaddr = refill_vaddr_q;
  assign refill_paddr = refill_paddr_q;
  assign walk_fault   = walk_fault_q;
  assign fault_vaddr  = fault_vaddr_q;

endmodule
